uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single 16-bit UART transmit word channel between N_REQ requesters, e.g. player position X/Y, start_game and score words.
- Grants requesters round-robin. Each 12-bit payload is framed as {4-bit tag, 12-bit payload}.
- Starts one word at a time and waits for transmit completion before the next. Enforces an inter-word gap and a completion timeout.
- Sits between the game-logic sources and the uart block, replacing the fixed-rotation word mux on the TX side.

Parameters:
- N_REQ, 4, number of requesters (2..8); requester i uses tag TAG_BASE+i.
- TAG_BASE, 0, tag of requester 0; TAG_BASE+N_REQ-1 must be <= 15.
- GAP_CYCLES, 16, idle clocks enforced after each tx_done before the next grant (0 = none).
- TIMEOUT_CYCLES, 1000000, clocks to wait for tx_done before abandoning a word.

Ports:
- clk  input  1  system clock (clk65MHz domain).
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i has a word pending; held until acked.
- req_data  input  12*N_REQ  payload of requester i at bits [12*i+11:12*i].
- req_ack  output  N_REQ  one-cycle pulse on bit i when requester i's word is taken.
- tx_ready  input  1  UART 16-to-8 converter can accept a word (conv16to8ready).
- tx_done  input  1  one-cycle pulse when both bytes of the current word have been sent.
- tx_data  output  16  framed word to the UART: {tag[3:0], payload[11:0]}.
- tx_start  output  1  one-cycle pulse; tx_data is valid on and after this cycle until the next start.
- busy  output  1  high in every state except IDLE.
- err_timeout  output  1  one-cycle pulse when a word is abandoned.

Behaviour:
- All outputs are registered.
- Reset (async): state=IDLE; req_ack=0, tx_start=0, tx_data=0, busy=0, err_timeout=0; gap/timeout counters=0; last-grant pointer=N_REQ-1, so requester 0 wins first. Reset mid-word returns to IDLE immediately, and the word is not retried.
- States:
  - IDLE: on an edge where any req_valid=1 and tx_ready=1, select the winner g = first set bit searching from (last+1) mod N_REQ upward with wrap. Then, registered, for exactly one cycle: tx_data={TAG_BASE+g, payload g}, tx_start=1, req_ack[g]=1. Set last=g; go to WAIT_DONE. If tx_ready=0, no grant and stay in IDLE.
  - WAIT_DONE: busy=1; timeout counter increments each clock.
    - On tx_done=1: clear counter; go to GAP if GAP_CYCLES>0, else IDLE.
    - On counter reaching TIMEOUT_CYCLES-1 without tx_done: err_timeout pulse; go to IDLE; the pointer keeps g.
    - tx_done and the timeout on the same edge: tx_done wins, no error.
  - GAP: load GAP_CYCLES on entry; decrement each clock; go to IDLE the clock after the count reaches 1. GAP therefore lasts exactly GAP_CYCLES clocks.
- Latency: a request visible in IDLE with tx_ready=1 gives tx_start/req_ack one clock later.
- Minimum spacing between tx_start pulses: 1 (start) + WAIT_DONE length + GAP_CYCLES + 1 (IDLE decision).
- tx_done in IDLE or GAP is ignored.
- A requester dropping req_valid before it is granted is simply not served; no ack is generated.
- req_data is sampled only on the grant edge; later changes do not alter tx_data.
- tx_data holds its value between starts.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0,... With requester k alone valid, k is granted every slot.
- Counter widths: $clog2(TIMEOUT_CYCLES+1) and $clog2(GAP_CYCLES+1); no wrap beyond the terminal count.

Test Plan:
- Reset, then req_valid=4'b0001, data0=12'h155, tx_ready=1 -> one clock later tx_start=1, req_ack=4'b0001, tx_data=16'h0155, busy=1. tx_done 40 clocks later -> busy stays high 16 more clocks, then 0.
- req_valid=4'b1111 held, tx_done returned 10 clocks after each start -> grant order 0,1,2,3,0; tags in tx_data[15:12] are 0,1,2,3,0; start spacing = 1+10+16+1 = 28 clocks.
- req_valid=4'b1010 with last=1 -> requester 3 granted next, then 1. Assert tx_ready=0 while requests are pending -> no tx_start until tx_ready returns high.
- TIMEOUT_CYCLES=100, no tx_done -> err_timeout pulses 100 clocks after tx_start, state returns to IDLE, and the next pending requester is granted on the following decision.
- Assert rst in the middle of WAIT_DONE and in the middle of GAP -> all outputs 0 asynchronously. After release, requester 0 has priority; a tx_done pulse arriving after reset causes no state change.
- tx_done and the timeout terminal count on the same clock -> no err_timeout, GAP entered.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 16-bit UART transmit word channel between N_REQ sources.
// Each granted word is framed {tag, payload}; completion timeout and an inter-word gap follow each word.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TAG_BASE       = 0,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [12*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ack,
  input  logic                  tx_ready,
  input  logic                  tx_done,
  output logic [15:0]           tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  err_timeout
);

  // state     | meaning
  // IDLE      | waiting for a pending request while the UART is ready
  // WAIT_DONE | word handed to the UART, waiting for tx_done or timeout
  // GAP       | enforced idle clocks after a completed word

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [PW-1:0] LAST_RST = PW'(N_REQ - 1);
  localparam logic [TW-1:0] TO_TC    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [PW:0]   N_WRAP   = (PW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   last, last_nxt;
  logic [TW-1:0]   to_cnt, to_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic [N_REQ-1:0] ack_nxt;
  logic [15:0]     data_nxt;
  logic            start_nxt;
  logic            busy_nxt;
  logic            err_nxt;

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [PW:0]     cand;
  logic [11:0]     grant_payload;
  logic [3:0]      grant_tag;

  // Search starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last;
    cand        = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = {1'b0, last} + (PW+1)'(off);
      if (cand >= N_WRAP) begin
        cand = cand - N_WRAP;
      end
      if (!grant_found && req_valid[cand[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    grant_payload = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        grant_payload = req_data[12*i +: 12];
      end
    end
    grant_tag = 4'(TAG_BASE) + 4'(grant_idx);
  end

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    to_cnt_nxt  = to_cnt;
    gap_cnt_nxt = gap_cnt;
    data_nxt    = tx_data;
    start_nxt   = 1'b0;
    ack_nxt     = '0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (grant_found && tx_ready) begin
          start_nxt          = 1'b1;
          ack_nxt[grant_idx] = 1'b1;
          data_nxt           = {grant_tag, grant_payload};
          last_nxt           = grant_idx;
          to_cnt_nxt         = '0;
          state_nxt          = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // Completion has priority over a timeout landing on the same clock.
        if (tx_done) begin
          to_cnt_nxt = '0;
          if (GAP_CYCLES > 0) begin
            gap_cnt_nxt = GAP_LOAD;
            state_nxt   = GAP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (to_cnt == TO_TC) begin
          err_nxt    = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt <= GW'(1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= LAST_RST;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      req_ack     <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      to_cnt      <= to_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      tx_data     <= data_nxt;
      tx_start    <= start_nxt;
      req_ack     <= ack_nxt;
      busy        <= busy_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed multi-cycle sequences and a
// randomized run compared against a cycle-count reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TAG = 0;
  localparam int GAP = 16;
  localparam int TO  = 100;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [12*N-1:0] req_data;
  logic [N-1:0]  req_ack;
  logic          tx_ready;
  logic          tx_done;
  logic [15:0]   tx_data;
  logic          tx_start;
  logic          busy;
  logic          err_timeout;

  uart_tx_arbiter #(
    .N_REQ(N), .TAG_BASE(TAG), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_ready(tx_ready), .tx_done(tx_done),
    .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 0;

  // Reference model: an open word ages one per clock, a finished word leaves a gap budget.
  bit          m_open;
  int          m_age;
  int          m_gap;
  int          m_last;
  logic [15:0] m_data;
  logic        m_start, m_err, m_busy;
  logic [N-1:0] m_ack;

  task automatic model_reset();
    m_open = 0; m_age = 0; m_gap = 0; m_last = N - 1;
    m_data = '0; m_start = 0; m_err = 0; m_busy = 0; m_ack = '0;
  endtask

  task automatic model_step();
    bit found;
    logic [12*N-1:0] sh;
    m_start = 0; m_ack = '0; m_err = 0;
    if (m_open) begin
      if (tx_done) begin
        m_open = 0; m_gap = GAP;
      end else if (m_age == TO - 1) begin
        m_open = 0; m_err = 1;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req_valid != 0 && tx_ready) begin
      found = 0;
      for (int off = 1; off <= N; off++) begin
        int g;
        g = (m_last + off) % N;
        if (!found && req_valid[g]) begin
          found = 1;
          sh = req_data >> (12 * g);
          m_data = {4'(TAG + g), sh[11:0]};
          m_ack[g] = 1'b1;
          m_start = 1;
          m_last = g;
          m_open = 1;
          m_age = 0;
        end
      end
    end
    m_busy = m_open || (m_gap > 0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    #1;
    cyc++;
    if (model_on) begin
      checks++;
      if ({tx_start, req_ack, tx_data, busy, err_timeout} !== {m_start, m_ack, m_data, m_busy, m_err}) begin
        errors++;
        $display("FAIL model cycle %0d: got start=%b ack=%b data=%h busy=%b err=%b expected start=%b ack=%b data=%h busy=%b err=%b",
                 cyc, tx_start, req_ack, tx_data, busy, err_timeout, m_start, m_ack, m_data, m_busy, m_err);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; tx_ready = 1'b0; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_start(input string name);
    int w;
    w = 0;
    while (!tx_start && w < 60) begin
      tick();
      w++;
    end
    if (!tx_start) begin
      checks++; errors++;
      $display("FAIL %s: no tx_start within 60 cycles", name);
    end
  endtask

  typedef struct {
    int          n;
    logic [3:0]  valid;
    logic        ready;
    logic        done;
    logic        start;
    logic [3:0]  ack;
    logic [15:0] data;
    logic        busy;
    logic        err;
  } vec_t;

  function automatic vec_t mk(int n, logic [3:0] v, logic r, logic d, logic s,
                              logic [3:0] a, logic [15:0] dat, logic b, logic e);
    vec_t x;
    x.n = n; x.valid = v; x.ready = r; x.done = d; x.start = s;
    x.ack = a; x.data = dat; x.busy = b; x.err = e;
    return x;
  endfunction

  vec_t vecs[16];
  int   t_prev;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b0; tx_done = 1'b0;

    vecs[0]  = mk(1,  4'b0001, 1, 0, 1, 4'b0001, 16'h0155, 1, 0);
    vecs[1]  = mk(39, 4'b0000, 1, 0, 0, 4'b0000, 16'h0155, 1, 0);
    vecs[2]  = mk(1,  4'b0000, 1, 1, 0, 4'b0000, 16'h0155, 1, 0);
    vecs[3]  = mk(15, 4'b0000, 1, 0, 0, 4'b0000, 16'h0155, 1, 0);
    vecs[4]  = mk(1,  4'b0000, 1, 0, 0, 4'b0000, 16'h0155, 0, 0);
    vecs[5]  = mk(1,  4'b0010, 1, 0, 1, 4'b0010, 16'h11A1, 1, 0);
    vecs[6]  = mk(1,  4'b1010, 1, 1, 0, 4'b0000, 16'h11A1, 1, 0);
    vecs[7]  = mk(16, 4'b1010, 0, 0, 0, 4'b0000, 16'h11A1, 0, 0);
    vecs[8]  = mk(5,  4'b1010, 0, 0, 0, 4'b0000, 16'h11A1, 0, 0);
    vecs[9]  = mk(1,  4'b1010, 1, 0, 1, 4'b1000, 16'h33C3, 1, 0);
    vecs[10] = mk(1,  4'b0010, 1, 1, 0, 4'b0000, 16'h33C3, 1, 0);
    vecs[11] = mk(16, 4'b0010, 1, 0, 0, 4'b0000, 16'h33C3, 0, 0);
    vecs[12] = mk(1,  4'b0010, 1, 0, 1, 4'b0010, 16'h11A1, 1, 0);
    vecs[13] = mk(1,  4'b0000, 1, 1, 0, 4'b0000, 16'h11A1, 1, 0);
    vecs[14] = mk(16, 4'b0000, 1, 0, 0, 4'b0000, 16'h11A1, 0, 0);
    vecs[15] = mk(3,  4'b0000, 1, 1, 0, 4'b0000, 16'h11A1, 0, 0);

    // Reset state
    do_reset();
    check("reset_outputs", {9'd0, tx_start, req_ack, tx_data, busy, err_timeout}, 32'd0);

    // Vector table
    req_data = {12'h3C3, 12'h2B2, 12'h1A1, 12'h155};
    for (int i = 0; i < 16; i++) begin
      req_valid = vecs[i].valid;
      tx_ready  = vecs[i].ready;
      tx_done   = vecs[i].done;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d", i), {9'd0, tx_start, req_ack, tx_data, busy, err_timeout},
            {9'd0, vecs[i].start, vecs[i].ack, vecs[i].data, vecs[i].busy, vecs[i].err});
    end
    tx_done = 1'b0;

    // Fairness with all requesters valid, tx_done 10 clocks after each start
    do_reset();
    req_valid = 4'b1111; tx_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start($sformatf("rr_start%0d", k));
      check($sformatf("rr_ack%0d", k), 32'(req_ack), 32'(1 << (k % N)));
      check($sformatf("rr_tag%0d", k), 32'(tx_data[15:12]), 32'(TAG + (k % N)));
      if (k > 0) check($sformatf("rr_spacing%0d", k), 32'(cyc - t_prev), 32'd28);
      t_prev = cyc;
      repeat (10) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end

    // Timeout, then the next pending requester is served
    do_reset();
    req_valid = 4'b0011; tx_ready = 1'b1;
    tick();
    check("to_first_ack", 32'(req_ack), 32'b0001);
    req_valid = 4'b0010;
    begin
      int early;
      early = 0;
      repeat (99) begin
        tick();
        if (err_timeout) early++;
      end
      check("to_no_early_err", 32'(early), 32'd0);
    end
    tick();
    check("to_err_pulse", {29'd0, err_timeout, busy, tx_start}, {29'd0, 1'b1, 1'b0, 1'b0});
    tick();
    check("to_next_grant", {27'd0, err_timeout, req_ack}, {27'd0, 1'b0, 4'b0010});
    req_valid = 4'b0000;

    // tx_done on the same clock as the timeout terminal count
    repeat (99) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("tie_no_err_gap", {30'd0, err_timeout, busy}, {30'd0, 1'b0, 1'b1});
    repeat (16) tick();
    check("tie_gap_end", 32'(busy), 32'd0);

    // Asynchronous reset in WAIT_DONE
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1 check("rst_wait_outputs", {9'd0, tx_start, req_ack, tx_data, busy, err_timeout}, 32'd0);
    #1 rst = 1'b0;
    tick();
    check("rst_wait_no_retry", {30'd0, tx_start, busy}, 32'd0);

    // Asynchronous reset in GAP, stray tx_done afterwards, requester 0 first
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (5) tick();
    check("gap_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_gap_outputs", {9'd0, tx_start, req_ack, tx_data, busy, err_timeout}, 32'd0);
    #1 rst = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("stray_done_idle", {30'd0, tx_start, busy}, 32'd0);
    req_valid = 4'b1001;
    tick();
    check("post_rst_priority", 32'(req_ack), 32'b0001);
    req_valid = 4'b0000;

    // Randomized run against the reference model
    do_reset();
    model_on = 1;
    for (int blk = 0; blk < 8; blk++) begin
      int pct;
      pct = (blk % 3 == 0) ? 25 : ((blk % 3 == 1) ? 4 : 0);
      for (int c = 0; c < 500; c++) begin
        req_valid = 4'($urandom_range(0, 15));
        req_data  = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
        tx_ready  = ($urandom_range(0, 99) < 80);
        tx_done   = (int'($urandom_range(0, 99)) < pct);
        tick();
      end
    end
    model_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
